// File: rtl/udcounter_param.sv
// ---------------------------------------------------------------------------
// udcounter_param
//   Parameterised up/down counter with a dynamic upper bound, a parallel
//   load, a selectable wrap or saturate policy at the bounds, a
//   combinational terminal-count flag and a registered one-cycle pulse for
//   every step that hits a bound.
//
// Parameters
//   WIDTH    counter width in bits (2..32)
//   SATURATE 0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset
//   en        in   count enable
//   x         in   direction, 0 = up, 1 = down
//   load      in   synchronous parallel load request
//   load_val  in   value to load (clamped to max_val)
//   max_val   in   upper bound, sampled every cycle; count range 0..max_val
//   q         out  registered count value
//   tc        out  combinational terminal count for the current direction
//   evt       out  registered one-cycle boundary-step pulse
// ---------------------------------------------------------------------------
module udcounter_param #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;

  // Boundary detection uses >= for the upper bound so that a count left
  // above a freshly lowered max_val still takes the boundary path going up.
  logic at_top;
  logic at_bottom;

  assign at_top    = (cnt_q >= max_val);
  assign at_bottom = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    evt_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (!x) begin
        if (at_top) begin
          cnt_d = SATURATE ? max_val : '0;
          evt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
          cnt_d = SATURATE ? '0 : max_val;
          evt_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  assign q   = cnt_q;
  assign evt = evt_q;
  assign tc  = (!x && at_top) || (x && at_bottom);

endmodule

// File: tb/tb_udcounter_param.sv
// ---------------------------------------------------------------------------
// tb_udcounter_param
//   Bench for udcounter_param. Two instances: a 3-bit wrapping counter and a
//   4-bit saturating counter. Expected q/evt/tc triples are queued when a
//   cycle's stimulus is applied and popped after the following rising edge.
// ---------------------------------------------------------------------------
module tb_udcounter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 3-bit wrapping instance
  logic       w_reset = 1'b1, w_en = 1'b0, w_x = 1'b0, w_load = 1'b0;
  logic [2:0] w_lv = '0, w_mx = '0, w_q;
  logic       w_tc, w_evt;

  // 4-bit saturating instance
  logic       s_reset = 1'b1, s_en = 1'b0, s_x = 1'b0, s_load = 1'b0;
  logic [3:0] s_lv = '0, s_mx = '0, s_q;
  logic       s_tc, s_evt;

  udcounter_param #(.WIDTH(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(w_reset), .en(w_en), .x(w_x), .load(w_load),
    .load_val(w_lv), .max_val(w_mx), .q(w_q), .tc(w_tc), .evt(w_evt)
  );

  udcounter_param #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(s_reset), .en(s_en), .x(s_x), .load(s_load),
    .load_val(s_lv), .max_val(s_mx), .q(s_q), .tc(s_tc), .evt(s_evt)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       evt;
    logic       tc;
  } exp_t;

  typedef struct packed {
    logic       rst, ld, en, x;
    logic [3:0] lv, mx;
    exp_t       e;
  } row_t;

  exp_t sb[$];
  exp_t sb_w[$];
  exp_t sb_s[$];

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic row_t mk(input logic rst, input logic ld, input logic en,
                              input logic x, input logic [3:0] lv,
                              input logic [3:0] mx, input logic [3:0] eq,
                              input logic eevt, input logic etc);
    row_t r;
    r.rst = rst; r.ld = ld; r.en = en; r.x = x;
    r.lv = lv; r.mx = mx;
    r.e.q = eq; r.e.evt = eevt; r.e.tc = etc;
    return r;
  endfunction

  // Drive one cycle on the chosen instance, idle the other, queue the
  // expectation, then step past the next rising edge.
  task automatic apply(input bit sat, input row_t r);
    if (sat) begin
      s_reset = r.rst; s_load = r.ld; s_en = r.en; s_x = r.x;
      s_lv = r.lv; s_mx = r.mx;
      w_reset = 1'b0; w_load = 1'b0; w_en = 1'b0;
    end else begin
      w_reset = r.rst; w_load = r.ld; w_en = r.en; w_x = r.x;
      w_lv = r.lv[2:0]; w_mx = r.mx[2:0];
      s_reset = 1'b0; s_load = 1'b0; s_en = 1'b0;
    end
    sb.push_back(r.e);
    @(posedge clk);
    #1;
  endtask

  // Independent reference: next {evt, q} from the current count and inputs.
  function automatic logic [4:0] model_next(input bit sat, input logic [3:0] cq,
                                            input logic rst, input logic ld,
                                            input logic en, input logic x,
                                            input logic [3:0] lv,
                                            input logic [3:0] mx);
    if (rst) return {1'b0, 4'd0};
    if (ld)  return {1'b0, (lv > mx) ? mx : lv};
    if (!en) return {1'b0, cq};
    if (!x) begin
      if (cq < mx) return {1'b0, cq + 4'd1};
      return {1'b1, sat ? mx : 4'd0};
    end
    if (cq != 4'd0) return {1'b0, cq - 4'd1};
    return {1'b1, sat ? 4'd0 : mx};
  endfunction

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(1, 1, 1, 1, 4'd3, 4'd5, 4'd0, 0, 1));
    rows.push_back(mk(1, 1, 1, 0, 4'd3, 4'd5, 4'd0, 0, 0));
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < rows.size(); i++) begin
        apply(s[0], rows[i]);
        e = sb.pop_front();
        obs = s[0] ? {s_q, s_evt, s_tc} : {1'b0, w_q, w_evt, w_tc};
        tests_run++;
        if (obs !== e) begin
          tests_failed++;
          $display("FAIL reset[%0d.%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                   s, i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
        end
      end
    end
  endtask

  task automatic test_wrap_up();
    row_t rows[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(1, 0, 0, 0, 4'd0, 4'd7, 4'd0, 0, 0));
    for (int k = 1; k <= 7; k++)
      rows.push_back(mk(0, 0, 1, 0, 4'd0, 4'd7, 4'(k), 0, (k == 7)));
    rows.push_back(mk(0, 0, 1, 0, 4'd0, 4'd7, 4'd0, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 4'd0, 4'd7, 4'd1, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(1'b0, rows[i]);
      e = sb.pop_front();
      obs = {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL wrap_up[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_wrap_down();
    row_t rows[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(1, 0, 0, 1, 4'd0, 4'd5, 4'd0, 0, 1));
    rows.push_back(mk(0, 0, 1, 1, 4'd0, 4'd5, 4'd5, 1, 0));
    for (int k = 4; k >= 0; k--)
      rows.push_back(mk(0, 0, 1, 1, 4'd0, 4'd5, 4'(k), 0, (k == 0)));
    rows.push_back(mk(0, 0, 1, 1, 4'd0, 4'd5, 4'd5, 1, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(1'b0, rows[i]);
      e = sb.pop_front();
      obs = {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL wrap_down[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_saturate();
    row_t rows[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(0, 1, 0, 0, 4'd8, 4'd9, 4'd8, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 4'd8, 4'd9, 4'd9, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 4'd8, 4'd9, 4'd9, 1, 1));
    rows.push_back(mk(0, 0, 1, 0, 4'd8, 4'd9, 4'd9, 1, 1));
    rows.push_back(mk(0, 0, 1, 1, 4'd8, 4'd9, 4'd8, 0, 0));
    rows.push_back(mk(0, 1, 0, 1, 4'd0, 4'd9, 4'd0, 0, 1));
    rows.push_back(mk(0, 0, 1, 1, 4'd0, 4'd9, 4'd0, 1, 1));
    rows.push_back(mk(0, 0, 1, 1, 4'd0, 4'd9, 4'd0, 1, 1));
    rows.push_back(mk(0, 0, 0, 1, 4'd0, 4'd9, 4'd0, 0, 1));
    for (int i = 0; i < rows.size(); i++) begin
      apply(1'b1, rows[i]);
      e = sb.pop_front();
      obs = {s_q, s_evt, s_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL saturate[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_load_clamp();
    row_t rows[$];
    bit   sel[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(0, 1, 1, 0, 4'd7, 4'd5, 4'd5, 0, 1));  sel.push_back(0);
    rows.push_back(mk(1, 1, 1, 0, 4'd7, 4'd5, 4'd0, 0, 0));  sel.push_back(0);
    rows.push_back(mk(0, 1, 1, 0, 4'd15, 4'd9, 4'd9, 0, 1)); sel.push_back(1);
    rows.push_back(mk(0, 1, 1, 1, 4'd4, 4'd9, 4'd4, 0, 0));  sel.push_back(1);
    for (int i = 0; i < rows.size(); i++) begin
      apply(sel[i], rows[i]);
      e = sb.pop_front();
      obs = sel[i] ? {s_q, s_evt, s_tc} : {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL load_clamp[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_bound_shrink();
    row_t rows[$];
    bit   sel[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(0, 1, 0, 0, 4'd6, 4'd7, 4'd6, 0, 0)); sel.push_back(0);
    rows.push_back(mk(0, 0, 1, 0, 4'd6, 4'd3, 4'd0, 1, 0)); sel.push_back(0);
    rows.push_back(mk(0, 1, 0, 0, 4'd6, 4'd7, 4'd6, 0, 0)); sel.push_back(0);
    rows.push_back(mk(0, 0, 1, 1, 4'd6, 4'd3, 4'd5, 0, 0)); sel.push_back(0);
    rows.push_back(mk(0, 0, 1, 0, 4'd6, 4'd3, 4'd0, 1, 0)); sel.push_back(0);
    rows.push_back(mk(0, 1, 0, 0, 4'd6, 4'd9, 4'd6, 0, 0)); sel.push_back(1);
    rows.push_back(mk(0, 0, 1, 0, 4'd6, 4'd3, 4'd3, 1, 1)); sel.push_back(1);
    for (int i = 0; i < rows.size(); i++) begin
      apply(sel[i], rows[i]);
      e = sb.pop_front();
      obs = sel[i] ? {s_q, s_evt, s_tc} : {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL bound_shrink[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_enable_gating();
    row_t rows[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(0, 1, 0, 0, 4'd2, 4'd7, 4'd2, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 4'd2, 4'd7, 4'd3, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 4'd2, 4'd7, 4'd3, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 4'd2, 4'd7, 4'd4, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 4'd2, 4'd7, 4'd4, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 4'd2, 4'd7, 4'd0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(1'b0, rows[i]);
      e = sb.pop_front();
      obs = {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL enable_gating[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_max_zero();
    row_t rows[$];
    exp_t e;
    logic [5:0] obs;
    rows.push_back(mk(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 1, 1));
    rows.push_back(mk(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 1, 1));
    rows.push_back(mk(0, 0, 1, 1, 4'd0, 4'd0, 4'd0, 1, 1));
    rows.push_back(mk(0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 1));
    rows.push_back(mk(0, 1, 1, 0, 4'd5, 4'd0, 4'd0, 0, 1));
    for (int i = 0; i < rows.size(); i++) begin
      apply(1'b0, rows[i]);
      e = sb.pop_front();
      obs = {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL max_zero[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    logic [5:0] obs;
    // Reset on the same edge as a boundary step, then release stepping from 0.
    rows.push_back(mk(0, 1, 0, 0, 4'd7, 4'd7, 4'd7, 0, 1));
    rows.push_back(mk(1, 0, 1, 0, 4'd7, 4'd7, 4'd0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 4'd7, 4'd7, 4'd1, 0, 0));
    // Pulse already out, then reset clears it.
    rows.push_back(mk(0, 1, 0, 0, 4'd7, 4'd7, 4'd7, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 4'd7, 4'd7, 4'd0, 1, 0));
    rows.push_back(mk(1, 0, 1, 0, 4'd7, 4'd7, 4'd0, 0, 0));
    // Same-cycle direction flips around zero.
    rows.push_back(mk(0, 0, 1, 1, 4'd7, 4'd7, 4'd7, 1, 0));
    rows.push_back(mk(0, 0, 1, 0, 4'd7, 4'd7, 4'd0, 1, 0));
    rows.push_back(mk(0, 0, 1, 1, 4'd7, 4'd7, 4'd7, 1, 0));
    rows.push_back(mk(0, 0, 1, 1, 4'd7, 4'd7, 4'd6, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(1'b0, rows[i]);
      e = sb.pop_front();
      obs = {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] mw = '0, ms = '0;
    logic [4:0] nw, ns;
    logic       rst, ld, en, x;
    logic [3:0] lvw, mxw, lvs, mxs;
    exp_t       ew, es, e;
    logic [5:0] obs;
    for (int i = 0; i < 300; i++) begin
      rst = (i == 0) || ($urandom_range(0, 24) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      x   = $urandom_range(0, 1) != 0;
      lvw = 4'($urandom_range(0, 7));
      mxw = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 7));
      w_reset = rst; w_load = ld; w_en = en; w_x = x;
      w_lv = lvw[2:0]; w_mx = mxw[2:0];
      nw = model_next(1'b0, mw, rst, ld, en, x, lvw, mxw);
      ew.q = nw[3:0]; ew.evt = nw[4];
      ew.tc = (!x && nw[3:0] >= mxw) || (x && nw[3:0] == 4'd0);
      sb_w.push_back(ew);
      mw = nw[3:0];

      rst = (i == 0) || ($urandom_range(0, 24) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      x   = $urandom_range(0, 1) != 0;
      lvs = 4'($urandom_range(0, 15));
      mxs = 4'($urandom_range(0, 15));
      s_reset = rst; s_load = ld; s_en = en; s_x = x;
      s_lv = lvs; s_mx = mxs;
      ns = model_next(1'b1, ms, rst, ld, en, x, lvs, mxs);
      es.q = ns[3:0]; es.evt = ns[4];
      es.tc = (!x && ns[3:0] >= mxs) || (x && ns[3:0] == 4'd0);
      sb_s.push_back(es);
      ms = ns[3:0];

      @(posedge clk);
      #1;

      e = sb_w.pop_front();
      obs = {1'b0, w_q, w_evt, w_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL random_wrap[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
      e = sb_s.pop_front();
      obs = {s_q, s_evt, s_tc};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL random_sat[%0d]: got q=%0d evt=%b tc=%b, want q=%0d evt=%b tc=%b",
                 i, obs[5:2], obs[1], obs[0], e.q, e.evt, e.tc);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_clamp();
    test_bound_shrink();
    test_enable_gating();
    test_max_zero();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
